// File: rtl/conv_out_fifo.sv
// conv_out_fifo: circular output buffer for convolution-layer results.
// The MAC array pushes through wr_en and the next stage pops through rd_en
// with a one-cycle registered read. Occupancy is kept in a separate level
// counter, so full and empty never depend on pointer comparison and the
// depth does not have to be a power of two. done flushes the buffer
// synchronously. Overflow and underflow are sticky until a flush or reset.
module conv_out_fifo #(
    parameter int IMAGE_PIXEL_WIDTH  = 8,
    parameter int KERNEL_PIXEL_WIDTH = 8,
    parameter int FIFO_DEPTH         = 9,
    parameter int AF_THRESH          = FIFO_DEPTH - 1,
    localparam int DW                = IMAGE_PIXEL_WIDTH + KERNEL_PIXEL_WIDTH,
    localparam int CW                = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          done,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic [CW-1:0] level,
    output logic          full_pulse,
    output logic          overflow,
    output logic          underflow,
    output logic [15:0]   fill_count
);

    // Pointer width; a depth of 2 still needs one address bit.
    localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CW-1:0] LEVEL_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LEVEL_AF   = CW'(AF_THRESH);
    localparam logic [PW-1:0] PTR_LAST   = PW'(FIFO_DEPTH - 1);

    // Storage, intentionally without reset so it maps onto block RAM.
    logic [DW-1:0] mem_q [FIFO_DEPTH];

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] level_q, level_d;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          full_d_q;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic [15:0]   fill_count_q, fill_count_d;

    logic          full_w;
    logic          empty_w;
    logic          full_pulse_w;
    logic          wr_accept;
    logic          rd_accept;

    // Status decoded purely from the level register (pre-edge state).
    assign full_w       = (level_q == LEVEL_FULL);
    assign empty_w      = (level_q == '0);
    assign full_pulse_w = full_w && !full_d_q;

    // A same-cycle pop never frees room for a push, nor does a push feed a pop;
    // both decisions look only at the registered level.
    assign wr_accept = wr_en && !full_w  && !done;
    assign rd_accept = rd_en && !empty_w && !done;

    // Next-state computation for pointers, level, sticky errors and counter.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        level_d      = level_q;
        overflow_d   = overflow_q;
        underflow_d  = underflow_q;
        fill_count_d = fill_count_q;

        if (done) begin
            wptr_d      = '0;
            rptr_d      = '0;
            level_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
            end
            if (rd_accept) begin
                rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
            end
            case ({wr_accept, rd_accept})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (wr_en && full_w) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty_w) begin
                underflow_d = 1'b1;
            end
        end

        // Counts rises of full independently of flushes; saturates at the top.
        if (full_pulse_w && (fill_count_q != 16'hFFFF)) begin
            fill_count_d = fill_count_q + 16'd1;
        end
    end

    // Memory write port.
    always_ff @(posedge clock) begin
        if (wr_accept) begin
            mem_q[wptr_q] <= wr_data;
        end
    end

    // Control state and registered read port, cleared asynchronously.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            full_d_q     <= 1'b0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
            fill_count_q <= '0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            full_d_q     <= full_w;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
            fill_count_q <= fill_count_d;
            rd_valid_q   <= rd_accept;
            if (rd_accept) begin
                rd_data_q <= mem_q[rptr_q];
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign almost_full = (level_q >= LEVEL_AF);
    assign level       = level_q;
    assign full_pulse  = full_pulse_w;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign fill_count  = fill_count_q;

endmodule

// File: tb/tb_conv_out_fifo.sv
// Bench for conv_out_fifo (depth 9, 16-bit data, almost_full threshold 7).
// A queue-based reference model tracks every output; table vectors and
// hand-written sequences add independently derived expectations.
module tb_conv_out_fifo;

    localparam int D  = 9;
    localparam int AF = 7;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        done = 1'b0;
    logic        wr_en = 1'b0;
    logic [15:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic [3:0]  level;
    logic        full_pulse;
    logic        overflow;
    logic        underflow;
    logic [15:0] fill_count;

    conv_out_fifo #(
        .IMAGE_PIXEL_WIDTH (8),
        .KERNEL_PIXEL_WIDTH(8),
        .FIFO_DEPTH        (D),
        .AF_THRESH         (AF)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .done       (done),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .full       (full),
        .empty      (empty),
        .almost_full(almost_full),
        .level      (level),
        .full_pulse (full_pulse),
        .overflow   (overflow),
        .underflow  (underflow),
        .fill_count (fill_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state
    logic [15:0] mq[$];
    logic        m_ovf, m_unf, m_rdv, m_pulse;
    logic [15:0] m_rdd;
    int          m_fc;

    typedef struct {
        logic        wr;
        logic [15:0] wd;
        logic        rd;
        int          lvl;
        logic        rdv;
        logic [15:0] rdd;
        logic        full;
        logic        empty;
        logic        af;
        logic        pulse;
        int          fc;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (txn %0d)", nm, act, exp, txn);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_unf = 0; m_rdv = 0; m_pulse = 0; m_rdd = '0; m_fc = 0;
    endtask

    // One clock edge of the FIFO rules, evaluated on the pre-edge state.
    task automatic model_step(input logic wr, input logic [15:0] wd, input logic rd, input logic dn);
        bit pre_full, wacc, racc;
        if (m_pulse && m_fc != 16'hFFFF) m_fc++;
        pre_full = (mq.size() == D);
        if (dn) begin
            mq.delete();
            m_ovf = 0; m_unf = 0; m_rdv = 0;
        end else begin
            wacc = wr && (mq.size() < D);
            racc = rd && (mq.size() > 0);
            if (wr && !wacc) m_ovf = 1;
            if (rd && !racc) m_unf = 1;
            m_rdv = racc;
            if (racc) m_rdd = mq.pop_front();
            if (wacc) mq.push_back(wd);
        end
        m_pulse = (mq.size() == D) && !pre_full;
    endtask

    task automatic check_model();
        chk("m_level",  32'(level),       32'(mq.size()));
        chk("m_empty",  32'(empty),       32'(mq.size() == 0));
        chk("m_full",   32'(full),        32'(mq.size() == D));
        chk("m_af",     32'(almost_full), 32'(mq.size() >= AF));
        chk("m_rdv",    32'(rd_valid),    32'(m_rdv));
        chk("m_rdd",    32'(rd_data),     32'(m_rdd));
        chk("m_pulse",  32'(full_pulse),  32'(m_pulse));
        chk("m_ovf",    32'(overflow),    32'(m_ovf));
        chk("m_unf",    32'(underflow),   32'(m_unf));
        chk("m_fc",     32'(fill_count),  32'(m_fc));
    endtask

    task automatic check_reset_values();
        chk("rst_rd_data",    32'(rd_data),     0);
        chk("rst_rd_valid",   32'(rd_valid),    0);
        chk("rst_full",       32'(full),        0);
        chk("rst_empty",      32'(empty),       1);
        chk("rst_af",         32'(almost_full), 0);
        chk("rst_level",      32'(level),       0);
        chk("rst_full_pulse", 32'(full_pulse),  0);
        chk("rst_overflow",   32'(overflow),    0);
        chk("rst_underflow",  32'(underflow),   0);
        chk("rst_fill_count", 32'(fill_count),  0);
    endtask

    // Drive one cycle of inputs, take the edge, then compare against the model.
    task automatic step(input logic wr, input logic [15:0] wd, input logic rd, input logic dn);
        wr_en = wr; wr_data = wd; rd_en = rd; done = dn;
        @(posedge clock);
        model_step(wr, wd, rd, dn);
        #1;
        txn++;
        $display("txn %0d wr=%0b wd=%04h rd=%0b done=%0b -> lvl=%0d rdv=%0b rdd=%04h ovf=%0b unf=%0b fc=%0d",
                 txn, wr, wd, rd, dn, level, rd_valid, rd_data, overflow, underflow, fill_count);
        check_model();
        wr_en = 0; rd_en = 0; done = 0;
    endtask

    int          peak;
    int          exp_val;
    int          fc_before;
    logic        rw, rr, rdn;
    logic [15:0] rdat;

    initial begin
        // Fill-and-drain vectors, derived from the ordering rules
        for (int i = 0; i < 9; i++) begin
            vecs[i] = '{wr: 1, wd: 16'(i + 1), rd: 0, lvl: i + 1, rdv: 0, rdd: 16'h0,
                        full: (i == 8), empty: 0, af: ((i + 1) >= AF), pulse: (i == 8), fc: 0};
        end
        for (int i = 0; i < 9; i++) begin
            vecs[9 + i] = '{wr: 0, wd: 16'h0, rd: 1, lvl: 8 - i, rdv: 1, rdd: 16'(i + 1),
                            full: 0, empty: (i == 8), af: ((8 - i) >= AF), pulse: 0, fc: 1};
        end

        model_reset();
        repeat (2) @(posedge clock);
        #2;
        check_reset_values();
        rst_n = 1'b1;
        #1;

        // Fill and drain
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].wr, vecs[i].wd, vecs[i].rd, 1'b0);
            chk("tv_level", 32'(level),       32'(vecs[i].lvl));
            chk("tv_rdv",   32'(rd_valid),    32'(vecs[i].rdv));
            chk("tv_rdd",   32'(rd_data),     32'(vecs[i].rdd));
            chk("tv_full",  32'(full),        32'(vecs[i].full));
            chk("tv_empty", 32'(empty),       32'(vecs[i].empty));
            chk("tv_af",    32'(almost_full), 32'(vecs[i].af));
            chk("tv_pulse", 32'(full_pulse),  32'(vecs[i].pulse));
            chk("tv_fc",    32'(fill_count),  32'(vecs[i].fc));
        end

        // Wrap-around: three rounds of six writes then six reads
        peak = 0;
        exp_val = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) begin
                step(1, 16'(r * 6 + i + 1), 0, 0);
                if (int'(level) > peak) peak = int'(level);
            end
            for (int i = 0; i < 6; i++) begin
                step(0, 16'h0, 1, 0);
                chk("wrap_order", 32'(rd_data), 32'(exp_val));
                exp_val++;
            end
        end
        chk("wrap_peak", 32'(peak), 6);
        chk("wrap_ovf",  32'(overflow), 0);
        chk("wrap_unf",  32'(underflow), 0);

        // Both requested while full
        for (int i = 0; i < 9; i++) step(1, 16'h100 + 16'(i), 0, 0);
        step(1, 16'hDEAD, 1, 0);
        chk("bf_ovf",   32'(overflow), 1);
        chk("bf_level", 32'(level),    8);
        chk("bf_rdv",   32'(rd_valid), 1);
        chk("bf_rdd",   32'(rd_data),  16'h100);
        for (int i = 0; i < 8; i++) step(0, 16'h0, 1, 0);
        step(0, 16'h0, 0, 1);
        chk("bf_clr", 32'(overflow), 0);

        // Both requested while empty
        step(1, 16'h0A0A, 1, 0);
        chk("be_unf",   32'(underflow), 1);
        chk("be_level", 32'(level),     1);
        chk("be_rdv",   32'(rd_valid),  0);
        step(0, 16'h0, 0, 1);

        // almost_full threshold
        for (int i = 0; i < 6; i++) step(1, 16'h200 + 16'(i), 0, 0);
        chk("af_at6", 32'(almost_full), 0);
        step(1, 16'h206, 0, 0);
        chk("af_at7", 32'(almost_full), 1);
        step(0, 16'h0, 1, 0);
        chk("af_rd7", 32'(almost_full), 0);
        chk("af_lvl", 32'(level), 6);
        step(0, 16'h0, 1, 0);

        // Flush at level 5 with both requests
        chk("fl_pre", 32'(level), 5);
        fc_before = int'(fill_count);
        step(1, 16'h5555, 1, 1);
        chk("fl_level", 32'(level),     0);
        chk("fl_empty", 32'(empty),     1);
        chk("fl_rdv",   32'(rd_valid),  0);
        chk("fl_ovf",   32'(overflow),  0);
        chk("fl_unf",   32'(underflow), 0);
        chk("fl_fc",    32'(fill_count), 32'(fc_before));
        step(1, 16'hBEEF, 0, 0);
        step(0, 16'h0, 1, 0);
        chk("fl_after", 32'(rd_data), 16'hBEEF);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            rw   = ($urandom_range(0, 99) < 55);
            rr   = ($urandom_range(0, 99) < 45);
            rdn  = ($urandom_range(0, 99) < 2);
            rdat = 16'($urandom);
            step(rw, rdat, rr, rdn);
        end

        // Reset dropped between edges at level 4
        step(0, 16'h0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 16'h300 + 16'(i), 0, 0);
        chk("mr_pre", 32'(level), 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        model_reset();
        #2;
        rst_n = 1'b1;
        step(1, 16'h7777, 0, 0);
        step(0, 16'h0, 1, 0);
        chk("mr_resume", 32'(rd_data), 16'h7777);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_out_fifo.md
# conv_out_fifo

Parametrised read/write output buffer for convolution-layer results. It generalises the write-only capture FIFO to a true circular FIFO with a registered read port, level and threshold flags, a frame flush, and sticky error flags. It sits between the MAC array output (producer, `oen`-driven) and the next layer or pooling stage (consumer). It is fully synthesizable and contains no file I/O.

## Interface
- IMAGE_PIXEL_WIDTH, 8, image operand width
- KERNEL_PIXEL_WIDTH, 8, kernel operand width; data width DW = IMAGE_PIXEL_WIDTH+KERNEL_PIXEL_WIDTH
- FIFO_DEPTH, 9, entry count, any value ≥2 (power of two not required)
- AF_THRESH, FIFO_DEPTH-1, almost_full asserts when level ≥ AF_THRESH; legal range 1..FIFO_DEPTH
- CW (derived, not overridable), $clog2(FIFO_DEPTH+1), level width
- Reset/clock: one clock; reset is asynchronous and active-low
- clock  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- done  in  1  frame end; synchronous flush
- wr_en  in  1  write request (producer `oen`)
- wr_data  in  DW  write data
- rd_en  in  1  read request
- rd_data  out  DW  read data, registered
- rd_valid  out  1  rd_data holds a newly popped entry
- full  out  1  level == FIFO_DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level ≥ AF_THRESH
- level  out  CW  current occupancy
- full_pulse  out  1  one-cycle pulse on each rise of full
- overflow  out  1  sticky: write rejected
- underflow  out  1  sticky: read rejected
- fill_count  out  16  number of rises of full, saturating at 16'hFFFF

## Operation
- Storage is a DW×FIFO_DEPTH array with wptr and rptr of width $clog2(FIFO_DEPTH).
  - Each pointer wraps explicitly from FIFO_DEPTH-1 to 0.
  - level is a separate counter; full and empty derive from level only.
- Write accept: wr_en && !full && !done. The entry is stored at wptr, then wptr advances.
- Read accept: rd_en && !empty && !done. rd_data <= mem[rptr], rptr advances, and rd_valid = 1 on the next cycle. Otherwise rd_valid = 0 and rd_data holds its value.
- Flags are evaluated on the pre-edge state. A same-cycle read does not free space for a write, and a same-cycle write does not satisfy a read.
- Both accepted in one cycle: level is unchanged.
- Write with full = 1: no store, overflow <= 1.
- Read with empty = 1: no pop, underflow <= 1.
- Both requested while full: read accepted, write rejected, overflow set, level becomes FIFO_DEPTH-1.
- Both requested while empty: write accepted, read rejected, underflow set, level becomes 1.
- done has priority over everything. In that cycle:
  - No write or pop occurs.
  - wptr, rptr, level, overflow and underflow are cleared.
  - rd_valid is 0 on the next cycle.
  - fill_count and rd_data are unchanged.
- full_pulse = full && !full_d, where full_d is full registered. full_pulse is high for exactly the first cycle full reads 1.
- fill_count increments on every cycle in which full_pulse is 1, and saturates at its maximum.
- Memory contents are not reset.

## Timing
- Reset values: rd_data 0, rd_valid 0, full 0, empty 1, almost_full 0, level 0, full_pulse 0, overflow 0, underflow 0, fill_count 0.
- All outputs are registered or decoded from registers only; none is combinational from inputs.
- Write-to-read latency: a write accepted at edge N is visible as empty = 0 after edge N. A read at edge N+1 gives rd_data/rd_valid after edge N+1.
- Read latency is 1 cycle.
- Full back-to-back throughput is 1 write and 1 read per cycle.
- Flag updates (full, empty, almost_full, level) take effect after the accepting edge, with no extra delay.
- full_pulse appears in the first cycle after the edge that made level == FIFO_DEPTH. fill_count reflects that pulse one edge later.
- Reset asserted mid-operation forces all reset values immediately (asynchronously), regardless of clock. Operation resumes on the first edge after rst_n rises.

## Test plan
- Fill and drain (DEPTH 9, DW 16):
  - Write 0x0001..0x0009 on consecutive cycles, then read 9 times.
  - full rises after the 9th write; full_pulse is high for 1 cycle; fill_count = 1.
  - rd_data = 0x0001..0x0009 in order, each with rd_valid; empty = 1 at the end.
- Wrap-around:
  - Do 3 rounds of write 6 / read 6 with values 1..18.
  - Output order is 1..18, no errors, and level peaks at 6.
  - Pointers wrap at index 8 → 0.
- Simultaneous requests at the boundaries:
  - At full, assert wr_en and rd_en together: read accepted, overflow = 1, level = 8.
  - At empty, assert both together: underflow = 1, level = 1, rd_valid = 0.
- almost_full with AF_THRESH = 7: asserts exactly after the 7th write and deasserts after the first read at level 7.
- Flush:
  - At level 5, assert done together with wr_en and rd_en.
  - Next cycle: level 0, empty 1, rd_valid 0, overflow/underflow 0, fill_count unchanged.
  - The next write/read pair returns the newly written value.
- Reset mid-fill: drop rst_n between clock edges at level 4; all outputs show reset values immediately, and fill_count = 0.
